// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register and its bench.
package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

endpackage : shreg_pkg

// File: rtl/shreg_bit_cnt.sv
// Mod-WIDTH shift counter with a registered wrap pulse marking each full word.
module shreg_bit_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             last_c;

    // Next count: clear wins, otherwise count shifts and wrap on the WIDTH-th.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        last_c = (cnt_q == CNT_W'(WIDTH - 1));
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (last_c) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and pulse flops; the pulse is rewritten every edge so it lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule : shreg_bit_cnt

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             word_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_c;
    logic             load_c;
    shift_mode_e      mode_c;

    // Mode multiplexer for the next register value and counter controls.
    always_comb begin
        q_d     = q_q;
        shift_c = 1'b0;
        load_c  = 1'b0;
        mode_c  = shift_mode_e'(mode);
        if (en) begin
            case (mode_c)
                MODE_SHR: begin
                    q_d     = {sin_r, q_q[WIDTH-1:1]};
                    shift_c = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], sin_l};
                    shift_c = 1'b1;
                end
                MODE_LOAD: begin
                    q_d    = pin;
                    load_c = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    shreg_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (shift_c),
        .clr  (load_c),
        .wrap (word_done)
    );

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=4.
module tb_univ_shift_reg;
    import shreg_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    shift_mode_e   mode_t = MODE_HOLD;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  pin = '0;
    logic [W-1:0]  q;
    logic          sout_r, sout_l, word_done;

    int tests  = 0;
    int fails  = 0;

    // Reference state: value as an integer, shifts since last load/reset, pulse.
    int unsigned m_q      = 0;
    int unsigned m_shifts = 0;
    bit          m_done   = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode_t),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pin       (pin),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer shifts, word complete every W shifts since load.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q      = 0;
            m_shifts = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (en) begin
                case (mode_t)
                    MODE_SHR: begin
                        m_q = (m_q >> 1) | (int'(sin_r) << (W - 1));
                        m_shifts++;
                        m_done = (m_shifts % W) == 0;
                    end
                    MODE_SHL: begin
                        m_q = ((m_q << 1) | int'(sin_l)) & MASK;
                        m_shifts++;
                        m_done = (m_shifts % W) == 0;
                    end
                    MODE_LOAD: begin
                        m_q      = int'(pin);
                        m_shifts = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_q", 32'(q), 32'(m_q));
        check("model_sout_r", 32'(sout_r), 32'(m_q & 1));
        check("model_sout_l", 32'(sout_l), 32'((m_q >> (W - 1)) & 1));
        check("model_word_done", 32'(word_done), 32'(m_done));
    end

    // Apply inputs just after a falling edge and advance one full cycle.
    task automatic step(input logic e, input shift_mode_e m, input logic sr,
                        input logic sl, input logic [W-1:0] p);
        en     = e;
        mode_t = m;
        sin_r  = sr;
        sin_l  = sl;
        pin    = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] exp_r [4];
    logic [3:0]   bits_r;
    logic [3:0]   sout_exp;
    logic [W-1:0] exp_l [4];
    logic [3:0]   bits_l;
    int           pulses;
    int           last_pulse;

    initial begin
        exp_r[0] = 4'b1101; exp_r[1] = 4'b0110; exp_r[2] = 4'b0011; exp_r[3] = 4'b1001;
        bits_r   = 4'b1001;   // sin_r sequence 1,0,0,1 (bit 3 first)
        sout_exp = 4'b1101;   // sout_r before edges 1,1,0,1
        exp_l[0] = 4'b0001; exp_l[1] = 4'b0011; exp_l[2] = 4'b0110; exp_l[3] = 4'b1101;
        bits_l   = 4'b1101;   // sin_l sequence 1,1,0,1

        @(negedge clk);
        check("reset_q", 32'(q), 32'h0);
        check("reset_done", 32'(word_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Async reset mid-shift with q=1010.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1010);
        check("pre_reset_q", 32'(q), 32'hA);
        en = 1'b1; mode_t = MODE_SHR; sin_r = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_q", 32'(q), 32'h0);
        check("async_reset_done", 32'(word_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, MODE_SHR, 1'b1, 1'b0, 4'h0);
        check("post_reset_shift", 32'(q), 32'h8);

        // Load 1011.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1011);
        check("load_q", 32'(q), 32'hB);
        check("load_sout_r", 32'(sout_r), 32'h1);
        check("load_sout_l", 32'(sout_l), 32'h1);
        check("load_done", 32'(word_done), 32'h0);

        // Shift right 1,0,0,1.
        for (int i = 0; i < 4; i++) begin
            check("shr_sout_before", 32'(sout_r), 32'(sout_exp[3-i]));
            step(1'b1, MODE_SHR, bits_r[3-i], 1'b0, 4'h0);
            check("shr_q", 32'(q), 32'(exp_r[i]));
            check("shr_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
        end
        step(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'h0);
        check("shr_done_after", 32'(word_done), 32'h0);

        // Shift left from 0000 with 1,1,0,1.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, MODE_SHL, 1'b0, bits_l[3-i], 4'h0);
            check("shl_q", 32'(q), 32'(exp_l[i]));
            check("shl_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
        end

        // Direction changes and holds do not disturb the count.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h5);
        step(1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0);
        check("dir_done_1", 32'(word_done), 32'h0);
        step(1'b1, MODE_SHL, 1'b0, 1'b1, 4'h0);
        check("dir_done_2", 32'(word_done), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, MODE_SHR, 1'b1, 1'b1, 4'hF);
            check("en_low_done", 32'(word_done), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, MODE_HOLD, 1'b1, 1'b1, 4'hF);
            check("hold_done", 32'(word_done), 32'h0);
        end
        step(1'b1, MODE_SHR, 1'b1, 1'b0, 4'h0);
        check("dir_done_3", 32'(word_done), 32'h0);
        step(1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0);
        check("dir_done_4", 32'(word_done), 32'h1);
        // Load in the word_done cycle clears the pulse.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h3);
        check("load_after_done_q", 32'(q), 32'h3);
        check("load_after_done", 32'(word_done), 32'h0);

        // Load mid-word restarts the count.
        for (int i = 0; i < 3; i++) step(1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0);
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h9);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
            check("midword_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
        end

        // Eight continuous shifts: two pulses, four cycles apart.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h6);
        pulses = 0;
        last_pulse = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, (i % 2 == 1) ? MODE_SHR : MODE_SHL, 1'($urandom), 1'($urandom), 4'h0);
            if (word_done) begin
                if (pulses == 1) check("pulse_spacing", 32'(i - last_pulse), 32'd4);
                pulses++;
                last_pulse = i;
            end
        end
        check("pulse_count", 32'(pulses), 32'd2);

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                step(1'($urandom_range(0, 7) != 0), shift_mode_e'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 4'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_univ_shift_reg
